// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_sched.sv
// Scan Write-Thru observation scheduler: round-robin shares one XOR-compaction
// and rotate-XOR signature stage among memory-port requesters, with a valid/ready readout.
//
// state | meaning
// IDLE  | waiting for start; signature and remaining held
// RUN   | arbitrating port requests and folding captures into the signature
// DRAIN | signature final, presented on sig_out/sig_vld until sig_rdy
module arf038b064e1r1w0cbbehraa4acw_swt_obs_sched #(
  parameter int NUM_PORTS    = 2,
  parameter int OBS_PIN_NUM  = 16,
  parameter int OBS_XOR_SIZE = 3,
  parameter int OBS_FLOP_NUM = (OBS_PIN_NUM + OBS_XOR_SIZE - 1) / OBS_XOR_SIZE,
  parameter int CNT_W        = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 num_captures,
  input  logic [NUM_PORTS-1:0]             req_vld,
  input  logic [NUM_PORTS*OBS_PIN_NUM-1:0] req_in,
  output logic [NUM_PORTS-1:0]             req_gnt,
  output logic                             busy,
  output logic [CNT_W-1:0]                 remaining,
  output logic [OBS_FLOP_NUM-1:0]          sig_out,
  output logic                             sig_vld,
  input  logic                             sig_rdy,
  output logic                             done
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [OBS_FLOP_NUM-1:0] sig_q, sig_d, sig_rot, obs;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d, gnt_idx, ptr_after;
  logic                    gnt_any;
  logic [OBS_PIN_NUM-1:0]  slice;
  logic [PTR_W:0]          scan;

  // Search from ptr_q upward with wrap; ptr_q and k are both below NUM_PORTS,
  // so a single conditional subtract is enough to wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_PORTS)) scan = scan - (PTR_W+1)'(NUM_PORTS);
      if (!gnt_any && req_vld[scan[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_idx == PTR_W'(p)) slice = req_in[p*OBS_PIN_NUM +: OBS_PIN_NUM];
    end
  end

  // The last group may be short when OBS_PIN_NUM is not a multiple of the group size.
  always_comb begin
    obs = '0;
    for (int i = 0; i < OBS_FLOP_NUM; i++) begin
      for (int b = 0; b < OBS_XOR_SIZE; b++) begin
        if (i*OBS_XOR_SIZE + b < OBS_PIN_NUM) obs[i] = obs[i] ^ slice[i*OBS_XOR_SIZE + b];
      end
    end
  end

  generate
    if (OBS_FLOP_NUM == 1) begin : g_rot1
      assign sig_rot = sig_q;
    end else begin : g_rotn
      assign sig_rot = {sig_q[OBS_FLOP_NUM-2:0], sig_q[OBS_FLOP_NUM-1]};
    end
  endgenerate

  assign ptr_after = (gnt_idx == PTR_W'(NUM_PORTS-1)) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    req_gnt = '0;
    busy    = 1'b0;
    sig_vld = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d   = '0;
          rem_d   = num_captures;
          state_d = (num_captures != '0) ? S_RUN : S_DRAIN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (gnt_any) begin
          req_gnt[gnt_idx] = 1'b1;
          sig_d = sig_rot ^ obs;
          rem_d = rem_q - CNT_W'(1);
          ptr_d = ptr_after;
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        sig_vld = 1'b1;
        if (sig_rdy) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sig_out   = sig_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_sched.sv
// Directed bench for the SWT observation scheduler with 2 ports, 4 pins per port,
// XOR groups of 3 (2-bit signature); expected values are hand-computed.
module tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_sched;

  localparam int NP  = 2;
  localparam int PIN = 4;
  localparam int XS  = 3;
  localparam int F   = 2;
  localparam int CW  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_captures;
  logic [NP-1:0] req_vld;
  logic [NP*PIN-1:0] req_in;
  logic [NP-1:0] req_gnt;
  logic          busy;
  logic [CW-1:0] remaining;
  logic [F-1:0]  sig_out;
  logic          sig_vld;
  logic          sig_rdy;
  logic          done;

  int n_chk = 0;
  int n_bad = 0;

  arf038b064e1r1w0cbbehraa4acw_swt_obs_sched #(
    .NUM_PORTS(NP), .OBS_PIN_NUM(PIN), .OBS_XOR_SIZE(XS), .OBS_FLOP_NUM(F), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_captures(num_captures),
    .req_vld(req_vld), .req_in(req_in), .req_gnt(req_gnt), .busy(busy),
    .remaining(remaining), .sig_out(sig_out), .sig_vld(sig_vld),
    .sig_rdy(sig_rdy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; comb outputs are checked #1 later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic launch(input logic [CW-1:0] n);
    start = 1'b1;
    num_captures = n;
    tick();
    start = 1'b0;
    num_captures = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_captures = '0;
    req_vld = '0; req_in = '0; sig_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    req_vld = 2'b11;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_sig", sig_out, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_vld", sig_vld, 0);
    chk("rst_done", done, 0);
    chk("idle_gnt", req_gnt, 0);
    req_vld = '0;

    // 1: single capture, port0 = 1011 -> obs 10
    launch(1);
    chk("t1_busy", busy, 1);
    chk("t1_rem", remaining, 1);
    req_vld = 2'b01; req_in = {4'b0000, 4'b1011};
    settle();
    chk("t1_gnt", req_gnt, 2'b01);
    tick();
    req_vld = '0;
    chk("t1_sig", sig_out, 2'b10);
    chk("t1_vld", sig_vld, 1);
    chk("t1_rem0", remaining, 0);
    sig_rdy = 1'b1;
    settle();
    chk("t1_done", done, 1);
    tick();
    sig_rdy = 1'b0;
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);

    // 2: two captures alternating ports
    do_reset();
    launch(2);
    req_vld = 2'b11; req_in = {4'b1000, 4'b0001};
    settle();
    chk("t2_gnt0", req_gnt, 2'b01);
    tick();
    chk("t2_sig0", sig_out, 2'b01);
    chk("t2_gnt1", req_gnt, 2'b10);
    tick();
    req_vld = '0;
    chk("t2_sig1", sig_out, 2'b00);
    chk("t2_vld", sig_vld, 1);
    sig_rdy = 1'b1;
    tick();
    sig_rdy = 1'b0;

    // 3: round-robin fairness with both ports always requesting
    launch(4);
    req_vld = 2'b11; req_in = '0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_gnt", req_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_rem", remaining, 4 - i);
      tick();
    end
    req_vld = '0;
    chk("t3_rem_end", remaining, 0);
    chk("t3_vld", sig_vld, 1);
    sig_rdy = 1'b1;
    tick();
    sig_rdy = 1'b0;

    // 4a: zero captures go straight to DRAIN with a zero signature
    launch(0);
    req_vld = 2'b11;
    settle();
    chk("t4_vld", sig_vld, 1);
    chk("t4_sig", sig_out, 0);
    chk("t4_gnt", req_gnt, 0);
    req_vld = '0;
    sig_rdy = 1'b1;
    tick();
    sig_rdy = 1'b0;

    // 4b: idle RUN cycles, then three captures from port1 only (obs 10 each)
    launch(3);
    for (int i = 0; i < 5; i++) begin
      chk("t4_idle_gnt", req_gnt, 0);
      chk("t4_idle_rem", remaining, 3);
      tick();
    end
    req_vld = 2'b10; req_in = {4'b1000, 4'b1111};
    settle();
    chk("t4_p1_gnt", req_gnt, 2'b10);
    tick(); chk("t4_sig_a", sig_out, 2'b10);
    tick(); chk("t4_sig_b", sig_out, 2'b11);
    tick(); chk("t4_sig_c", sig_out, 2'b01);
    req_vld = '0;

    // 5: backpressure in DRAIN; start pulses must be ignored
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      num_captures = 8'd7;
      settle();
      chk("t5_vld", sig_vld, 1);
      chk("t5_sig", sig_out, 2'b01);
      chk("t5_done", done, 0);
      chk("t5_rem", remaining, 0);
      tick();
    end
    start = 1'b0; num_captures = '0;
    sig_rdy = 1'b1;
    settle();
    chk("t5_done_rise", done, 1);
    tick();
    sig_rdy = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_done_off", done, 0);

    // 6: reset after two of five captures (obs 10, 10 -> sig 11)
    launch(5);
    req_vld = 2'b11; req_in = {4'b1000, 4'b1011};
    tick(); tick();
    chk("t6_sig_mid", sig_out, 2'b11);
    chk("t6_rem_mid", remaining, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_vld = '0;
    chk("t6_busy", busy, 0);
    chk("t6_sig", sig_out, 0);
    chk("t6_rem", remaining, 0);
    sig_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6_no_done", done, 0);
      chk("t6_no_vld", sig_vld, 0);
      tick();
    end
    sig_rdy = 1'b0;
    launch(1);
    req_vld = 2'b11; req_in = {4'b1000, 4'b1011};
    settle();
    chk("t6_gnt", req_gnt, 2'b01);
    tick();
    req_vld = '0;
    chk("t6_sig_new", sig_out, 2'b10);
    sig_rdy = 1'b1;
    settle();
    chk("t6_done", done, 1);
    tick();
    sig_rdy = 1'b0;
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
